// File: rtl/data_path.sv
// ---------------------------------------------------------------------------
// data_path
//
// 8-bit CPU datapath. It holds the program counter (PC), two general
// registers (A, B), the instruction register (IR), the memory address
// register (MAR) and a 4-bit condition code register (CCR). Two internal
// buses and an 8-bit ALU connect them. An external control unit drives every
// select and load strobe each cycle.
//
// Bus1 sources : PC, A, B or zero. Bus1 also feeds the memory write data.
// Bus2 sources : ALU result, Bus1, memory read data or zero. Bus2 feeds
//                every register load.
// ALU operands : X = Bus1, Y = register B.
//
// Optional feature, controlled by the macro DATA_PATH_EXT_ALU_EN:
//   defined   - ALU_Sel 1xx selects XOR / NOT / INC / DEC.
//   undefined - ALU_Sel 1xx passes X through, with N/Z from X and V=C=0.
//
// Parameters:
//   PC_RESET_VAL  value loaded into PC by reset.
//
// Ports:
//   Clk          in   1  system clock, rising edge
//   Reset        in   1  asynchronous, active-high reset
//   from_memory  in   8  memory read data (Bus2 source)
//   ALU_Sel      in   3  ALU operation select
//   Bus1_Sel     in   2  Bus1 source: 00 PC, 01 A, 10 B, 11 zero
//   Bus2_Sel     in   2  Bus2 source: 00 ALU, 01 Bus1, 10 memory, 11 zero
//   IR_Load      in   1  IR  <= Bus2
//   MAR_Load     in   1  MAR <= Bus2
//   PC_Load      in   1  PC  <= Bus2 (takes priority over PC_Inc)
//   PC_Inc       in   1  PC  <= PC + 1
//   A_Load       in   1  A   <= Bus2
//   B_Load       in   1  B   <= Bus2
//   CCR_Load     in   1  CCR <= ALU flags {N,Z,V,C}
//   address      out  8  MAR contents
//   to_memory    out  8  Bus1 (combinational)
//   IR_out       out  8  IR contents
//   CCR_Result   out  4  CCR contents {N,Z,V,C}
// ---------------------------------------------------------------------------
module data_path #(
    parameter logic [7:0] PC_RESET_VAL = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] from_memory,
    input  logic [2:0] ALU_Sel,
    input  logic [1:0] Bus1_Sel,
    input  logic [1:0] Bus2_Sel,
    input  logic       IR_Load,
    input  logic       MAR_Load,
    input  logic       PC_Load,
    input  logic       PC_Inc,
    input  logic       A_Load,
    input  logic       B_Load,
    input  logic       CCR_Load,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic [7:0] IR_out,
    output logic [3:0] CCR_Result
);

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
`ifdef DATA_PATH_EXT_ALU_EN
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_INC = 3'b110;
    localparam logic [2:0] ALU_DEC = 3'b111;
`endif

    // Bus source encodings
    localparam logic [1:0] B1_PC   = 2'b00;
    localparam logic [1:0] B1_A    = 2'b01;
    localparam logic [1:0] B1_B    = 2'b10;
    localparam logic [1:0] B2_ALU  = 2'b00;
    localparam logic [1:0] B2_BUS1 = 2'b01;
    localparam logic [1:0] B2_MEM  = 2'b10;

    // Architectural registers and their next-state values
    logic [7:0] pc_q,  pc_d;
    logic [7:0] a_q,   a_d;
    logic [7:0] b_q,   b_d;
    logic [7:0] ir_q,  ir_d;
    logic [7:0] mar_q, mar_d;
    logic [3:0] ccr_q, ccr_d;

    // Combinational buses and ALU signals
    logic [7:0] bus1_s;
    logic [7:0] bus2_s;
    logic [8:0] alu_wide_s;
    logic [7:0] alu_result_s;
    logic       alu_v_s;
    logic       alu_c_s;
    logic [3:0] alu_flags_s;

    // Signed overflow of X + Y: operands share a sign that the result lacks.
    function automatic logic add_overflow(input logic x_msb,
                                          input logic y_msb,
                                          input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

    // Signed overflow of X - Y: operands differ in sign and the result sign
    // differs from X.
    function automatic logic sub_overflow(input logic x_msb,
                                          input logic y_msb,
                                          input logic r_msb);
        return (x_msb != y_msb) && (r_msb != x_msb);
    endfunction

    // Bus1 source multiplexer
    always_comb begin
        bus1_s = 8'h00;
        case (Bus1_Sel)
            B1_PC:   bus1_s = pc_q;
            B1_A:    bus1_s = a_q;
            B1_B:    bus1_s = b_q;
            default: bus1_s = 8'h00;
        endcase
    end

    // ALU: result plus V and C. The 9-bit sum/difference carries the
    // carry-out or borrow in bit 8.
    always_comb begin
        alu_wide_s   = 9'h000;
        alu_result_s = 8'h00;
        alu_v_s      = 1'b0;
        alu_c_s      = 1'b0;
        case (ALU_Sel)
            ALU_ADD: begin
                alu_wide_s   = {1'b0, bus1_s} + {1'b0, b_q};
                alu_result_s = alu_wide_s[7:0];
                alu_c_s      = alu_wide_s[8];
                alu_v_s      = add_overflow(bus1_s[7], b_q[7], alu_wide_s[7]);
            end
            ALU_AND: begin
                alu_result_s = bus1_s & b_q;
            end
            ALU_SUB: begin
                // Bit 8 of the 9-bit difference is set exactly when X < Y.
                alu_wide_s   = {1'b0, bus1_s} - {1'b0, b_q};
                alu_result_s = alu_wide_s[7:0];
                alu_c_s      = alu_wide_s[8];
                alu_v_s      = sub_overflow(bus1_s[7], b_q[7], alu_wide_s[7]);
            end
            ALU_OR: begin
                alu_result_s = bus1_s | b_q;
            end
`ifdef DATA_PATH_EXT_ALU_EN
            ALU_XOR: begin
                alu_result_s = bus1_s ^ b_q;
            end
            ALU_NOT: begin
                alu_result_s = ~bus1_s;
            end
            ALU_INC: begin
                alu_wide_s   = {1'b0, bus1_s} + 9'h001;
                alu_result_s = alu_wide_s[7:0];
                alu_c_s      = alu_wide_s[8];
                alu_v_s      = add_overflow(bus1_s[7], 1'b0, alu_wide_s[7]);
            end
            ALU_DEC: begin
                alu_wide_s   = {1'b0, bus1_s} - 9'h001;
                alu_result_s = alu_wide_s[7:0];
                alu_c_s      = alu_wide_s[8];
                alu_v_s      = sub_overflow(bus1_s[7], 1'b0, alu_wide_s[7]);
            end
`endif
            default: begin
                // Unimplemented codes pass X through untouched.
                alu_result_s = bus1_s;
            end
        endcase
    end

    // Condition flags {N,Z,V,C} taken from the current ALU result
    always_comb begin
        alu_flags_s = {alu_result_s[7], (alu_result_s == 8'h00), alu_v_s, alu_c_s};
    end

    // Bus2 source multiplexer
    always_comb begin
        bus2_s = 8'h00;
        case (Bus2_Sel)
            B2_ALU:  bus2_s = alu_result_s;
            B2_BUS1: bus2_s = bus1_s;
            B2_MEM:  bus2_s = from_memory;
            default: bus2_s = 8'h00;
        endcase
    end

    // Next-state selection; each register loads independently from Bus2
    always_comb begin
        pc_d  = pc_q;
        a_d   = a_q;
        b_d   = b_q;
        ir_d  = ir_q;
        mar_d = mar_q;
        ccr_d = ccr_q;

        // An explicit load wins over increment; increment wraps at 8 bits.
        if (PC_Load) begin
            pc_d = bus2_s;
        end else if (PC_Inc) begin
            pc_d = pc_q + 8'd1;
        end else begin
            pc_d = pc_q;
        end

        if (A_Load) begin
            a_d = bus2_s;
        end else begin
            a_d = a_q;
        end

        if (B_Load) begin
            b_d = bus2_s;
        end else begin
            b_d = b_q;
        end

        if (IR_Load) begin
            ir_d = bus2_s;
        end else begin
            ir_d = ir_q;
        end

        if (MAR_Load) begin
            mar_d = bus2_s;
        end else begin
            mar_d = mar_q;
        end

        if (CCR_Load) begin
            ccr_d = alu_flags_s;
        end else begin
            ccr_d = ccr_q;
        end
    end

    // Register bank with asynchronous reset overriding every load
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q  <= PC_RESET_VAL;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            ir_q  <= 8'h00;
            mar_q <= 8'h00;
            ccr_q <= 4'b0000;
        end else begin
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            ccr_q <= ccr_d;
        end
    end

    // Outputs: register contents, plus Bus1 as memory write data
    assign address    = mar_q;
    assign to_memory  = bus1_s;
    assign IR_out     = ir_q;
    assign CCR_Result = ccr_q;

endmodule

// File: tb/tb_data_path.sv
// ---------------------------------------------------------------------------
// tb_data_path
//
// Directed and randomized checks of data_path against a behavioural model
// that tracks each architectural register with plain integer arithmetic.
// Build with +define+DATA_PATH_EXT_ALU_EN to check the extended ALU codes.
// ---------------------------------------------------------------------------
module tb_data_path;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] from_memory = 8'h00;
    logic [2:0] ALU_Sel = 3'b000;
    logic [1:0] Bus1_Sel = 2'b00;
    logic [1:0] Bus2_Sel = 2'b00;
    logic       IR_Load = 1'b0;
    logic       MAR_Load = 1'b0;
    logic       PC_Load = 1'b0;
    logic       PC_Inc = 1'b0;
    logic       A_Load = 1'b0;
    logic       B_Load = 1'b0;
    logic       CCR_Load = 1'b0;
    logic [7:0] address;
    logic [7:0] to_memory;
    logic [7:0] IR_out;
    logic [3:0] CCR_Result;

    int n_cmp = 0;
    int n_err = 0;

    // Reference register state
    logic [7:0] m_pc, m_a, m_b, m_ir, m_mar;
    logic [3:0] m_ccr;

    // Load strobe bit positions for drive(): {IR,MAR,PC,INC,A,B,CCR}
    localparam logic [6:0] L_NONE = 7'b0000000;
    localparam logic [6:0] L_IR   = 7'b1000000;
    localparam logic [6:0] L_MAR  = 7'b0100000;
    localparam logic [6:0] L_PC   = 7'b0010000;
    localparam logic [6:0] L_INC  = 7'b0001000;
    localparam logic [6:0] L_A    = 7'b0000100;
    localparam logic [6:0] L_B    = 7'b0000010;
    localparam logic [6:0] L_CCR  = 7'b0000001;

    always #5 Clk = ~Clk;

    data_path #(.PC_RESET_VAL(8'h00)) dut (
        .Clk(Clk), .Reset(Reset), .from_memory(from_memory),
        .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load),
        .PC_Inc(PC_Inc), .A_Load(A_Load), .B_Load(B_Load),
        .CCR_Load(CCR_Load), .address(address), .to_memory(to_memory),
        .IR_out(IR_out), .CCR_Result(CCR_Result)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00;
        m_ir = 8'h00; m_mar = 8'h00; m_ccr = 4'h0;
    endtask

    function automatic logic [7:0] m_bus1(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_pc;
            2'd1:    return m_a;
            2'd2:    return m_b;
            default: return 8'h00;
        endcase
    endfunction

    // Returns {N,Z,V,C,result[7:0]} computed with signed/unsigned integers.
    function automatic logic [11:0] m_alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int xi, yi, sx, sy, r, sr;
        logic c, v;
        logic [7:0] res;
        xi = int'(x); yi = int'(y);
        sx = (xi > 127) ? xi - 256 : xi;
        sy = (yi > 127) ? yi - 256 : yi;
        c = 1'b0; v = 1'b0; r = 0; sr = 0;
        case (op)
            3'd0: begin r = xi + yi; c = (r > 255); sr = sx + sy; v = (sr > 127) || (sr < -128); end
            3'd1: r = xi & yi;
            3'd2: begin r = xi - yi; c = (xi < yi); sr = sx - sy; v = (sr > 127) || (sr < -128); end
            3'd3: r = xi | yi;
`ifdef DATA_PATH_EXT_ALU_EN
            3'd4: r = xi ^ yi;
            3'd5: r = 255 - xi;
            3'd6: begin r = xi + 1; c = (r > 255); sr = sx + 1; v = (sr > 127); end
            3'd7: begin r = xi - 1; c = (xi < 1); sr = sx - 1; v = (sr < -128); end
`endif
            default: r = xi;
        endcase
        res = r[7:0];
        return {res[7], (res == 8'h00), v, c, res};
    endfunction

    // Apply one rising edge to the model using the currently driven inputs.
    task automatic model_edge();
        logic [7:0]  b1, b2;
        logic [11:0] al;
        b1 = m_bus1(Bus1_Sel);
        al = m_alu(ALU_Sel, b1, m_b);
        case (Bus2_Sel)
            2'd0:    b2 = al[7:0];
            2'd1:    b2 = b1;
            2'd2:    b2 = from_memory;
            default: b2 = 8'h00;
        endcase
        if (IR_Load)  m_ir  = b2;
        if (MAR_Load) m_mar = b2;
        if (A_Load)   m_a   = b2;
        if (B_Load)   m_b   = b2;
        if (CCR_Load) m_ccr = al[11:8];
        if (PC_Load)     m_pc = b2;
        else if (PC_Inc) m_pc = m_pc + 8'd1;
    endtask

    task automatic drive(input logic [1:0] b1, input logic [1:0] b2, input logic [2:0] alu,
                         input logic [7:0] mem, input logic [6:0] ld);
        Bus1_Sel = b1; Bus2_Sel = b2; ALU_Sel = alu; from_memory = mem;
        {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = ld;
    endtask

    // Check Bus1 before the edge, clock once, then check the registers.
    task automatic do_cycle(input string tag);
        #1;
        chk({tag, ":to_memory"}, to_memory, m_bus1(Bus1_Sel));
        model_edge();
        @(posedge Clk);
        #1;
        chk({tag, ":address"}, address, m_mar);
        chk({tag, ":IR_out"}, IR_out, m_ir);
        chk({tag, ":CCR"}, {4'h0, CCR_Result}, {4'h0, m_ccr});
    endtask

    task automatic peek(input string tag, input logic [1:0] b1, input logic [7:0] exp);
        Bus1_Sel = b1;
        #1;
        chk(tag, to_memory, exp);
    endtask

    initial begin
        model_reset();

        // Reset state, observed while Reset is still asserted
        #12;
        chk("rst_address", address, 8'h00);
        chk("rst_IR", IR_out, 8'h00);
        chk("rst_CCR", {4'h0, CCR_Result}, 8'h00);
        chk("rst_PC", to_memory, 8'h00);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Memory loads into each register in turn
        drive(2'd0, 2'd2, 3'd0, 8'hAA, L_A);   do_cycle("ldA");
        drive(2'd0, 2'd2, 3'd0, 8'h55, L_B);   do_cycle("ldB");
        drive(2'd0, 2'd2, 3'd0, 8'h12, L_IR);  do_cycle("ldIR");
        chk("IR_12", IR_out, 8'h12);
        drive(2'd0, 2'd2, 3'd0, 8'h35, L_PC);  do_cycle("ldPC");
        drive(2'd0, 2'd2, 3'd0, 8'hF0, L_MAR); do_cycle("ldMAR");
        chk("MAR_F0", address, 8'hF0);
        drive(2'd0, 2'd2, 3'd0, 8'h00, L_NONE);
        peek("bus1_A", 2'd1, 8'hAA);
        peek("bus1_B", 2'd2, 8'h55);
        peek("bus1_PC", 2'd0, 8'h35);

        // PC increment, load priority, and wrap
        drive(2'd0, 2'd2, 3'd0, 8'h00, L_INC); do_cycle("inc1");
        peek("pc_36", 2'd0, 8'h36);
        drive(2'd0, 2'd2, 3'd0, 8'h00, L_INC); do_cycle("inc2");
        peek("pc_37", 2'd0, 8'h37);
        drive(2'd0, 2'd2, 3'd0, 8'hFF, L_PC | L_INC); do_cycle("ld_over_inc");
        peek("pc_FF", 2'd0, 8'hFF);
        drive(2'd0, 2'd2, 3'd0, 8'h00, L_INC); do_cycle("wrap");
        peek("pc_wrap", 2'd0, 8'h00);

        // ADD AA+55 = FF -> N only
        drive(2'd1, 2'd1, 3'd0, 8'h00, L_CCR); do_cycle("add_ff");
        chk("ccr_add_ff", {4'h0, CCR_Result}, 8'h08);
        // SUB B-B = 00 -> Z only, then move the result into A
        drive(2'd2, 2'd1, 3'd2, 8'h00, L_CCR); do_cycle("sub_zero");
        chk("ccr_sub_zero", {4'h0, CCR_Result}, 8'h04);
        drive(2'd2, 2'd0, 3'd2, 8'h00, L_A); do_cycle("alu_to_A");
        peek("A_zero", 2'd1, 8'h00);

        // 7F+01 = 80 -> N and V
        drive(2'd0, 2'd2, 3'd0, 8'h7F, L_A); do_cycle("ld7F");
        drive(2'd0, 2'd2, 3'd0, 8'h01, L_B); do_cycle("ld01");
        drive(2'd1, 2'd0, 3'd0, 8'h00, L_CCR | L_IR); do_cycle("add_ovf");
        chk("add_ovf_res", IR_out, 8'h80);
        chk("add_ovf_ccr", {4'h0, CCR_Result}, 8'h0A);
        // 00-01 = FF -> N and C
        drive(2'd0, 2'd2, 3'd0, 8'h00, L_A); do_cycle("ld00");
        drive(2'd1, 2'd0, 3'd2, 8'h00, L_CCR | L_IR); do_cycle("sub_brw");
        chk("sub_brw_res", IR_out, 8'hFF);
        chk("sub_brw_ccr", {4'h0, CCR_Result}, 8'h09);

        // ALU code 101 on X=0F
        drive(2'd0, 2'd2, 3'd0, 8'h0F, L_A); do_cycle("ld0F");
        drive(2'd1, 2'd0, 3'd5, 8'h00, L_CCR | L_IR); do_cycle("op101");
`ifdef DATA_PATH_EXT_ALU_EN
        chk("not_res", IR_out, 8'hF0);
        chk("not_ccr", {4'h0, CCR_Result}, 8'h08);
`else
        chk("pass_res", IR_out, 8'h0F);
        chk("pass_ccr", {4'h0, CCR_Result}, 8'h00);
`endif

        // Reset asserted mid-operation while loads are pending
        drive(2'd1, 2'd2, 3'd0, 8'h77, L_IR | L_MAR | L_A | L_CCR | L_PC);
        Reset = 1'b1;
        #1;
        chk("mid_rst_A", to_memory, 8'h00);
        chk("mid_rst_address", address, 8'h00);
        chk("mid_rst_IR", IR_out, 8'h00);
        chk("mid_rst_CCR", {4'h0, CCR_Result}, 8'h00);
        @(posedge Clk);
        #1;
        chk("rst_hold_A", to_memory, 8'h00);
        chk("rst_hold_address", address, 8'h00);
        chk("rst_hold_IR", IR_out, 8'h00);
        peek("rst_hold_PC", 2'd0, 8'h00);
        model_reset();
        drive(2'd0, 2'd0, 3'd0, 8'h00, L_NONE);
        Reset = 1'b0;
        do_cycle("post_rst");

        // Randomized control sequences against the model
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ld;
            ld = L_NONE;
            for (int k = 0; k < 7; k++) begin
                ld[k] = ($urandom_range(0, 9) < 3);
            end
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 8'($urandom), ld);
            do_cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
